// File: rtl/rfprog_pkg.sv
// Shared types and constants for the RF synthesizer channel programmer.
package rfprog_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitCh,
      StShift,
      StLatch,
      StSettle
   } rfprog_st_e;

   localparam int unsigned WORD_W   = 16;
   localparam logic [6:0]  MAX_CHAN = 7'd78;

   // Synthesizer write word: register address, TX/RX select, channel index.
   function automatic logic [WORD_W-1:0] rfprog_word(input logic [7:0] addr,
                                                     input logic       tx,
                                                     input logic [6:0] chan);
      return {addr, tx, chan};
   endfunction

endpackage

// File: rtl/rfprog_shifter.sv
// 16-bit MSB-first serialiser with SCK divider for the synthesizer 3-wire bus.
module rfprog_shifter
   import rfprog_pkg::*;
#(
   parameter int unsigned DIV = 3
) (
   input  logic              clk_6M,
   input  logic              rstz,
   input  logic              i_start,
   input  logic [WORD_W-1:0] i_word,
   output logic              o_done,
   output logic              o_spi_clk,
   output logic              o_spi_data
);

   localparam int unsigned PH_MAX = 2 * DIV - 1;

   logic [4:0]        r_ph;
   logic [3:0]        r_bit;
   logic              r_active;
   logic              r_sck;
   logic [WORD_W-1:0] r_sreg;
   logic              w_ph_last;

   assign w_ph_last = r_active && (r_ph == 5'(PH_MAX));

   // Data and SCK both move at the end of a bit: SCK falls while the next bit is presented.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_ph     <= '0;
         r_bit    <= '0;
         r_active <= 1'b0;
         r_sck    <= 1'b0;
         r_sreg   <= '0;
      end else if (i_start) begin
         r_ph     <= '0;
         r_bit    <= 4'(WORD_W - 1);
         r_active <= 1'b1;
         r_sck    <= 1'b0;
         r_sreg   <= i_word;
      end else if (r_active) begin
         if (w_ph_last) begin
            r_ph   <= '0;
            r_sck  <= 1'b0;
            r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
            if (r_bit == 4'd0) begin
               r_active <= 1'b0;
            end else begin
               r_bit <= r_bit - 4'd1;
            end
         end else begin
            r_ph  <= r_ph + 5'd1;
            r_sck <= ((r_ph + 5'd1) >= 5'(DIV));
         end
      end
   end

   assign o_done     = w_ph_last && (r_bit == 4'd0);
   assign o_spi_clk  = r_sck;
   assign o_spi_data = r_active && r_sreg[WORD_W-1];

endmodule

// File: rtl/rf_chan_prog.sv
// Hop channel programmer: writes the hop-kernel channel to the RF synth, then waits PLL settle.
// Optional RFPROG_STATS_EN adds saturating overrun/error counters.
module rf_chan_prog
   import rfprog_pkg::*;
#(
   parameter int unsigned DIV        = 3,
   parameter int unsigned PLL_SETTLE = 900,
   parameter int unsigned CHAN_TO    = 15,
   parameter logic [7:0]  RF_ADDR    = 8'h0A
) (
   input  logic       clk_6M,
   input  logic       rstz,
   input  logic       i_fk_chg_p_ff,
   input  logic       i_chan_vld,
   input  logic [6:0] i_chan_in,
   input  logic       i_tx_mode,
   output logic       o_spi_clk,
   output logic       o_spi_data,
   output logic       o_spi_le,
   output logic       o_busy,
   output logic [6:0] o_cur_chan,
   output logic       o_pll_ready_p,
   output logic       o_overrun_p,
`ifdef RFPROG_STATS_EN
   output logic [7:0] o_overrun_cnt,
   output logic [7:0] o_err_cnt,
`endif
   output logic       o_err_p
);

   rfprog_st_e  r_state, w_state_nxt;
   logic [11:0] r_cnt, w_cnt_nxt;
   logic [6:0]  r_chan;
   logic [6:0]  r_cur_chan;
   logic        w_start;
   logic        w_err;
   logic        w_ready;
   logic        w_cur_upd;
   logic        w_chan_bad;
   logic        w_done;

   assign w_chan_bad = (i_chan_in > MAX_CHAN);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_err       = 1'b0;
      w_ready     = 1'b0;
      w_cur_upd   = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_fk_chg_p_ff) begin
               if (i_chan_vld) begin
                  if (w_chan_bad) begin
                     w_err = 1'b1;
                  end else begin
                     w_start     = 1'b1;
                     w_state_nxt = StShift;
                  end
               end else begin
                  w_state_nxt = StWaitCh;
                  w_cnt_nxt   = 12'(CHAN_TO);
               end
            end
         end
         StWaitCh: begin
            if (i_chan_vld) begin
               if (w_chan_bad) begin
                  w_err       = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_start     = 1'b1;
                  w_state_nxt = StShift;
               end
            end else if (r_cnt == 12'd1) begin
               w_err       = 1'b1;
               w_state_nxt = StIdle;
            end else begin
               w_cnt_nxt = r_cnt - 12'd1;
            end
         end
         StShift: begin
            if (w_done) begin
               w_state_nxt = StLatch;
               w_cnt_nxt   = 12'(2 * DIV);
            end
         end
         StLatch: begin
            if (r_cnt == 12'd1) begin
               w_cur_upd   = 1'b1;
               w_state_nxt = StSettle;
               w_cnt_nxt   = 12'(PLL_SETTLE);
            end else begin
               w_cnt_nxt = r_cnt - 12'd1;
            end
         end
         StSettle: begin
            if (r_cnt == 12'd1) begin
               w_ready     = 1'b1;
               w_state_nxt = StIdle;
            end else begin
               w_cnt_nxt = r_cnt - 12'd1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_chan     <= '0;
         r_cur_chan <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start) begin
            r_chan <= i_chan_in;
         end
         if (w_cur_upd) begin
            r_cur_chan <= r_chan;
         end
      end
   end

   rfprog_shifter #(
      .DIV (DIV)
   ) u_shifter (
      .clk_6M     (clk_6M),
      .rstz       (rstz),
      .i_start    (w_start),
      .i_word     (rfprog_word(RF_ADDR, i_tx_mode, i_chan_in)),
      .o_done     (w_done),
      .o_spi_clk  (o_spi_clk),
      .o_spi_data (o_spi_data)
   );

   // Outputs decode straight from state so a reset drops them without waiting for a clock.
   assign o_spi_le      = (r_state == StLatch);
   assign o_busy        = (r_state != StIdle);
   assign o_cur_chan    = r_cur_chan;
   assign o_pll_ready_p = w_ready;
   assign o_err_p       = w_err;
   assign o_overrun_p   = i_fk_chg_p_ff && (r_state != StIdle);

`ifdef RFPROG_STATS_EN
   logic [7:0] r_overrun_cnt;
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_overrun_cnt <= '0;
         r_err_cnt     <= '0;
      end else begin
         if (o_overrun_p && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
         end
         if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign o_overrun_cnt = r_overrun_cnt;
   assign o_err_cnt     = r_err_cnt;
`endif

endmodule

// File: tb/tb_rf_chan_prog.sv
// Directed bench for rf_chan_prog; checks stats counters when RFPROG_STATS_EN is defined.
module tb_rf_chan_prog;

   logic       clk_6M = 1'b0;
   logic       rstz   = 1'b0;
   logic       i_fk_chg_p_ff = 1'b0;
   logic       i_chan_vld    = 1'b0;
   logic [6:0] i_chan_in     = '0;
   logic       i_tx_mode     = 1'b0;
   logic       o_spi_clk, o_spi_data, o_spi_le, o_busy;
   logic [6:0] o_cur_chan;
   logic       o_pll_ready_p, o_overrun_p, o_err_p;
`ifdef RFPROG_STATS_EN
   logic [7:0] o_overrun_cnt, o_err_cnt;
`endif

   always #5 clk_6M = ~clk_6M;

   rf_chan_prog u_dut (
      .clk_6M        (clk_6M),
      .rstz          (rstz),
      .i_fk_chg_p_ff (i_fk_chg_p_ff),
      .i_chan_vld    (i_chan_vld),
      .i_chan_in     (i_chan_in),
      .i_tx_mode     (i_tx_mode),
      .o_spi_clk     (o_spi_clk),
      .o_spi_data    (o_spi_data),
      .o_spi_le      (o_spi_le),
      .o_busy        (o_busy),
      .o_cur_chan    (o_cur_chan),
      .o_pll_ready_p (o_pll_ready_p),
      .o_overrun_p   (o_overrun_p),
`ifdef RFPROG_STATS_EN
      .o_overrun_cnt (o_overrun_cnt),
      .o_err_cnt     (o_err_cnt),
`endif
      .o_err_p       (o_err_p)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   typedef struct {
      int          first_le;
      int          last_le;
      int          rdy_at;
      int          err_at;
      int          ovr_at;
      int          idle_at;
      int          nedge;
      logic [15:0] word;
   } rec_t;

   // Cycle 0 carries the trigger; events are logged by cycle number relative to it.
   task automatic run_op(input int vld_dly, input logic [6:0] chan, input logic tx,
                         input int ovr_cyc, input int ncyc, output rec_t r);
      logic prev_sck;
      r = '{first_le: -1, last_le: -1, rdy_at: -1, err_at: -1, ovr_at: -1, idle_at: -1,
            nedge: 0, word: 16'h0};
      prev_sck = o_spi_clk;
      for (int c = 0; c < ncyc; c++) begin
         i_fk_chg_p_ff = (c == 0) || (c == ovr_cyc);
         i_chan_vld    = (c == vld_dly);
         i_chan_in     = chan;
         i_tx_mode     = tx;
         #1;
         if (o_spi_le) begin
            if (r.first_le < 0) r.first_le = c;
            r.last_le = c;
         end
         if (o_pll_ready_p && r.rdy_at < 0) r.rdy_at = c;
         if (o_err_p && r.err_at < 0) r.err_at = c;
         if (o_overrun_p && r.ovr_at < 0) r.ovr_at = c;
         if (c > 0 && !o_busy && r.idle_at < 0) r.idle_at = c;
         if (o_spi_clk && !prev_sck) begin
            r.word = {r.word[14:0], o_spi_data};
            r.nedge++;
         end
         prev_sck = o_spi_clk;
         @(posedge clk_6M);
         #1;
      end
      i_fk_chg_p_ff = 1'b0;
      i_chan_vld    = 1'b0;
   endtask

   task automatic check_case1(input string pfx, input rec_t r);
      check({pfx, "_word"}, int'(r.word), 32'h0AA5);
      check({pfx, "_nedge"}, r.nedge, 16);
      check({pfx, "_le_first"}, r.first_le, 97);
      check({pfx, "_le_last"}, r.last_le, 102);
      check({pfx, "_rdy"}, r.rdy_at, 1002);
      check({pfx, "_idle"}, r.idle_at, 1003);
      check({pfx, "_err"}, r.err_at, -1);
      check({pfx, "_cur"}, int'(o_cur_chan), 37);
   endtask

   rec_t r;

   initial begin
      repeat (3) @(posedge clk_6M);
      #1;
      check("rst_busy", int'(o_busy), 0);
      check("rst_sck", int'(o_spi_clk), 0);
      check("rst_data", int'(o_spi_data), 0);
      check("rst_le", int'(o_spi_le), 0);
      check("rst_cur", int'(o_cur_chan), 0);
      check("rst_rdy", int'(o_pll_ready_p), 0);
      rstz = 1'b1;
      @(posedge clk_6M);
      #1;

      // Case 1: trigger with channel 37, TX.
      run_op(0, 7'd37, 1'b1, -1, 1010, r);
      check_case1("c1", r);
      check("c1_ovr", r.ovr_at, -1);

      // Case 4: out-of-range channel is rejected, previous channel retained.
      run_op(0, 7'd79, 1'b0, -1, 10, r);
      check("c4_err", r.err_at, 0);
      check("c4_nedge", r.nedge, 0);
      check("c4_idle", r.idle_at, 1);
      check("c4_cur", int'(o_cur_chan), 37);

      // Case 2: channel arrives five cycles after the trigger.
      run_op(5, 7'd0, 1'b0, -1, 1015, r);
      check("c2_word", int'(r.word), 32'h0A00);
      check("c2_nedge", r.nedge, 16);
      check("c2_le_first", r.first_le, 102);
      check("c2_rdy", r.rdy_at, 1007);
      check("c2_cur", int'(o_cur_chan), 0);

      // Case 3: channel never arrives.
      run_op(-1, 7'd10, 1'b0, -1, 30, r);
      check("c3_err", r.err_at, 15);
      check("c3_nedge", r.nedge, 0);
      check("c3_idle", r.idle_at, 16);
      check("c3_le", r.first_le, -1);

      // Case 5: second trigger mid-shift is an overrun and changes nothing.
      run_op(0, 7'd37, 1'b1, 50, 1010, r);
      check_case1("c5", r);
      check("c5_ovr", r.ovr_at, 50);
`ifdef RFPROG_STATS_EN
      check("c5_ovr_cnt", int'(o_overrun_cnt), 1);
      check("c5_err_cnt", int'(o_err_cnt), 2);
`endif

      // Case 6: asynchronous reset during the SCK-high phase of a bit.
      run_op(0, 7'd37, 1'b1, -1, 60, r);
      check("c6_pre_sck", int'(o_spi_clk), 1);
      check("c6_pre_busy", int'(o_busy), 1);
      rstz = 1'b0;
      #1;
      check("c6_sck", int'(o_spi_clk), 0);
      check("c6_data", int'(o_spi_data), 0);
      check("c6_le", int'(o_spi_le), 0);
      check("c6_busy", int'(o_busy), 0);
      check("c6_cur", int'(o_cur_chan), 0);
`ifdef RFPROG_STATS_EN
      check("c6_ovr_cnt", int'(o_overrun_cnt), 0);
      check("c6_err_cnt", int'(o_err_cnt), 0);
`endif
      @(posedge clk_6M);
      #1;
      rstz = 1'b1;
      @(posedge clk_6M);
      #1;
      run_op(0, 7'd37, 1'b1, -1, 1010, r);
      check_case1("c6r", r);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
